// File: rtl/chip8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// chip8_mem_arbiter
// Shares one synchronous RAM between three requesters:
//   port 0 = ROM loader, port 1 = CPU, port 2 = draw engine.
// Each cycle one eligible port wins. Its address, write data and write enable
// are registered onto the RAM bus together with a one-hot grant pulse. Read
// data comes back two cycles after the request was sampled, with a one-hot
// rvalid pulse.
//
// Build option: define CHIP8_ARB_RR_EN to round-robin between ports 1 and 2.
// Port 0 keeps absolute priority either way. Without the macro the priority is
// fixed at 0 > 1 > 2 and the round-robin pointer does not exist.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   req        in   [3]          per-port request
//   we         in   [3]          per-port write flag, qualified by req
//   addr       in   [3*ADDR_W]   per-port address, port i at [i*ADDR_W +: ADDR_W]
//   wdata      in   [3*DATA_W]   per-port write data, same packing
//   gnt        out  [3]          one-hot grant pulse
//   rvalid     out  [3]          one-hot read-data-valid pulse
//   rdata      out  [DATA_W]     read data, mem_rdata passed straight through
//   wp_fault   out  1            pulses with gnt[1] when a CPU write is blocked
//   busy       out  1            a grant or a read return is in flight
//   mem_addr   out  [ADDR_W]     RAM address
//   mem_we     out  1            RAM write enable
//   mem_wdata  out  [DATA_W]     RAM write data
//   mem_rdata  in   [DATA_W]     RAM read data, one cycle after mem_addr
// ---------------------------------------------------------------------------
module chip8_mem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WP_LIMIT = 32'h0000_0200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  wp_fault,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned NPORT    = 3;
  localparam int unsigned CPU_PORT = 1;

  // Registered state
  logic [NPORT-1:0]  gnt_q,       gnt_d;
  logic [NPORT-1:0]  rd_pend_q,   rd_pend_d;
  logic [NPORT-1:0]  rvalid_q,    rvalid_d;
  logic              wp_fault_q,  wp_fault_d;
  logic              busy_q,      busy_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Arbitration signals
  logic [NPORT-1:0]  eligible;
  logic [NPORT-1:0]  win_oh;
  logic              win_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic              blocked;

  // A port holding its grant this cycle is not re-sampled, so a request left
  // high after its grant only counts again one cycle later.
  assign eligible = req & ~gnt_q;

`ifdef CHIP8_ARB_RR_EN
  // rr_ptr_q = 0 favours port 1, 1 favours port 2
  logic rr_ptr_q, rr_ptr_d;

  // Port 0 first; a tie between ports 1 and 2 is settled by the pointer
  always_comb begin : arb_select
    win_oh   = '0;
    rr_ptr_d = rr_ptr_q;
    if (eligible[0]) begin
      win_oh = 3'b001;
    end else if (eligible[1] && eligible[2]) begin
      win_oh = rr_ptr_q ? 3'b100 : 3'b010;
    end else if (eligible[1]) begin
      win_oh = 3'b010;
    end else if (eligible[2]) begin
      win_oh = 3'b100;
    end
    // Point away from whichever of ports 1/2 just won
    if (win_oh[1]) begin
      rr_ptr_d = 1'b1;
    end else if (win_oh[2]) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge reset) begin : rr_ptr_reg
    if (!reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority, lowest port index wins
  always_comb begin : arb_select
    win_oh = '0;
    if (eligible[0]) begin
      win_oh = 3'b001;
    end else if (eligible[1]) begin
      win_oh = 3'b010;
    end else if (eligible[2]) begin
      win_oh = 3'b100;
    end
  end
`endif

  assign win_any = |win_oh;

  // Route the winning port's request fields
  always_comb begin : sel_mux
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (win_oh[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_we    = we[i];
      end
    end
  end

  // Only the CPU is write-protected. The grant still goes out so the CPU is
  // not left waiting, but the write never reaches RAM.
  assign cpu_addr = addr[CPU_PORT*ADDR_W +: ADDR_W];
  assign blocked  = win_oh[CPU_PORT] & we[CPU_PORT] & (32'(cpu_addr) < WP_LIMIT);

  // Next-state for the grant, RAM bus and read-return pipeline
  always_comb begin : next_state
    gnt_d       = win_oh;
    rd_pend_d   = win_oh & ~we;
    rvalid_d    = rd_pend_q;
    wp_fault_d  = blocked;
    busy_d      = win_any | (|rd_pend_d);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (win_any) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_we_d    = sel_we & ~blocked;
    end
  end

  // State registers. An asserted reset drops any pending read return and
  // de-asserts mem_we at once, so no write lands after reset.
  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      gnt_q       <= '0;
      rd_pend_q   <= '0;
      rvalid_q    <= '0;
      wp_fault_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rd_pend_q   <= rd_pend_d;
      rvalid_q    <= rvalid_d;
      wp_fault_q  <= wp_fault_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign wp_fault  = wp_fault_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // Structural invariants of the grant and return pulses
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(gnt_q));
  a_rvalid_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(rvalid_q));
  a_wp_fault_cpu : assert property (@(posedge clk) disable iff (!reset)
    wp_fault_q |-> (gnt_q[CPU_PORT] && !mem_we_q));
  a_we_with_gnt : assert property (@(posedge clk) disable iff (!reset)
    mem_we_q |-> (|gnt_q));

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_chip8_mem_arbiter
// Drives random and directed traffic on the three ports of chip8_mem_arbiter
// and connects the arbiter to a behavioural synchronous RAM. A request-level
// model decides, from the arbitration rules, which port is served each cycle.
// From that decision it queues the expected grant and, for reads, the expected
// data return. A monitor on the falling edge pops the queues and compares.
// Define CHIP8_ARB_RR_EN for both the bench and the RTL to exercise the
// round-robin build.
// ---------------------------------------------------------------------------
module tb_chip8_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int NP = 3;
`ifdef CHIP8_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            wp_fault;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  chip8_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .wp_fault  (wp_fault),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous RAM, read-first
  logic [DW-1:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            stamp;
    int            port;
    logic [AW-1:0] a;
    logic          wr;
    logic [DW-1:0] d;
    logic          wpf;
  } gexp_t;

  typedef struct {
    int            stamp;
    int            port;
    logic [DW-1:0] d;
    bit            known;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    glog[$];

  // Reference model state
  logic [DW-1:0] mram   [0:4095];
  bit            mknown [0:4095];
  int            favour;
  bit [2:0]      mgnt, mgnt_next;
  bit [2:0]      start, hold;
  logic [AW-1:0] n_addr [NP];
  logic          n_we   [NP];
  logic [DW-1:0] n_data [NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Which port is served among the eligible ones
  function automatic int pick(input bit [2:0] elig, input int fav);
    if (elig[0]) return 0;
    if (RR && elig[1] && elig[2]) return fav;
    if (elig[1]) return 1;
    if (elig[2]) return 2;
    return -1;
  endfunction

  // Request a new transaction on port p; it starts once the port is idle
  task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    n_we[p]   = w;
    n_addr[p] = a;
    n_data[p] = d;
    start[p]  = 1'b1;
  endtask

  // One cycle of stimulus plus the model's decision for that cycle
  task automatic tick();
    bit [2:0]      elig;
    int            w;
    logic [AW-1:0] a;
    gexp_t         g;
    rexp_t         r;
    @(posedge clk);
    #1;
    mgnt = mgnt_next;
    for (int p = 0; p < NP; p++) begin
      if (req[p] && mgnt[p] && !hold[p]) begin
        req[p] = 1'b0;
      end else if (start[p] && !req[p] && !mgnt[p]) begin
        req[p]              = 1'b1;
        we[p]               = n_we[p];
        addr[p*AW +: AW]    = n_addr[p];
        wdata[p*DW +: DW]   = n_data[p];
        start[p]            = 1'b0;
      end
    end
    elig      = req & ~mgnt;
    w         = pick(elig, favour);
    mgnt_next = '0;
    if (w >= 0) begin
      mgnt_next[w] = 1'b1;
      a       = addr[w*AW +: AW];
      g.stamp = cyc + 1;
      g.port  = w;
      g.a     = a;
      g.wr    = we[w];
      g.d     = wdata[w*DW +: DW];
      g.wpf   = (w == 1) && we[w] && (a < 12'h200);
      gq.push_back(g);
      if (we[w]) begin
        if (!g.wpf) begin
          mram[a]   = g.d;
          mknown[a] = 1'b1;
        end
      end else begin
        r.stamp = cyc + 2;
        r.port  = w;
        r.d     = mram[a];
        r.known = mknown[a];
        rq.push_back(r);
      end
      if (w != 0) favour = (w == 1) ? 2 : 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Monitor / scoreboard
  gexp_t         mg;
  rexp_t         mr;
  logic [AW-1:0] last_addr;
  always @(negedge clk) begin
    if (!reset) begin
      gq.delete();
      rq.delete();
      last_addr = '0;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_wp_fault", 32'(wp_fault), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    end else begin
      if (gnt != 3'b000) begin
        glog.push_back(gnt == 3'b001 ? 0 : gnt == 3'b010 ? 1 : gnt == 3'b100 ? 2 : -1);
        if (gq.size() == 0) begin
          fail("unexpected_gnt", int'(gnt), 0);
        end else begin
          mg = gq.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(mg.stamp));
          chk("gnt", 32'(gnt), 32'(3'b001 << mg.port));
          chk("mem_addr", 32'(mem_addr), 32'(mg.a));
          chk("mem_we", 32'(mem_we), 32'(mg.wr & ~mg.wpf));
          chk("mem_wdata", 32'(mem_wdata), 32'(mg.d));
          chk("wp_fault", 32'(wp_fault), 32'(mg.wpf));
          chk("busy_gnt", 32'(busy), 32'd1);
          last_addr = mg.a;
        end
      end else begin
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_wp_fault", 32'(wp_fault), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_addr_hold", 32'(mem_addr), 32'(last_addr));
        if (gq.size() > 0 && gq[0].stamp <= cyc) begin
          mg = gq.pop_front();
          fail("missing_gnt_port", -1, mg.port);
        end
      end
      if (rvalid != 3'b000) begin
        if (rq.size() == 0) begin
          fail("unexpected_rvalid", int'(rvalid), 0);
        end else begin
          mr = rq.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(mr.stamp));
          chk("rvalid", 32'(rvalid), 32'(3'b001 << mr.port));
          if (mr.known) chk("rdata", 32'(rdata), 32'(mr.d));
        end
      end else if (rq.size() > 0 && rq[0].stamp <= cyc) begin
        mr = rq.pop_front();
        fail("missing_rvalid_port", -1, mr.port);
      end
    end
  end

  // Safety net against a hung run
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    start = '0; hold = '0; mgnt = '0; mgnt_next = '0; favour = 1;
    for (int i = 0; i < 4096; i++) begin
      mram[i]   = '0;
      mknown[i] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      n_addr[p] = '0; n_we[p] = 1'b0; n_data[p] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;

    // Preload the working window through the ROM-loader port
    for (int a = 12'h1F8; a <= 12'h207; a++) begin
      issue(0, 1'b1, AW'(a), DW'($urandom));
      run(2);
    end
    issue(0, 1'b1, 12'h200, 8'hA2); run(2);
    issue(0, 1'b1, 12'h1FF, 8'h33); run(3);

    // CPU read of 0x200 returns 0xA2
    issue(1, 1'b0, 12'h200, 8'h00); run(4);

    // Protected CPU write is dropped; the one at the limit goes through
    issue(1, 1'b1, 12'h1FF, 8'h55); run(3);
    issue(1, 1'b0, 12'h1FF, 8'h00); run(4);
    chk("ram_1ff_unchanged", 32'(ram[12'h1FF]), 32'h33);
    issue(1, 1'b1, 12'h200, 8'h55); run(3);
    chk("ram_200_written", 32'(ram[12'h200]), 32'h55);
    issue(1, 1'b0, 12'h200, 8'h00); run(4);

    // Ports 1 and 2 held high together: grants must alternate
    glog.delete();
    hold = 3'b110;
    issue(1, 1'b0, 12'h200, 8'h00);
    issue(2, 1'b0, 12'h1FF, 8'h00);
    run(6);
    hold = '0;
    run(4);
    if (glog.size() >= 4) begin
      if (!RR) chk("hold_first_is_p1", 32'(glog[0]), 32'd1);
      for (int i = 0; i < 3; i++) chk("hold_alternate", 32'(glog[i+1]), 32'(3 - glog[i]));
    end else begin
      fail("hold_grant_count", glog.size(), 4);
    end

    // All three ports at once: port 0 goes first
    glog.delete();
    issue(0, 1'b0, 12'h1F8, 8'h00);
    issue(1, 1'b1, 12'h201, 8'h77);
    issue(2, 1'b0, 12'h201, 8'h00);
    run(6);
    if (glog.size() >= 3) begin
      chk("all3_first_p0", 32'(glog[0]), 32'd0);
      if (!RR) chk("all3_second_p1", 32'(glog[1]), 32'd1);
    end else begin
      fail("all3_grant_count", glog.size(), 3);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!start[p] && !req[p] && $urandom_range(0, 99) < 40)
          issue(p, 1'($urandom_range(0, 1)), AW'(12'h1F8 + $urandom_range(0, 15)), DW'($urandom));
      end
      tick();
    end
    run(8);

    // Reset pulse between a port-2 read grant and its data return
    issue(2, 1'b0, 12'h200, 8'h00);
    run(2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    req = '0; start = '0; hold = '0;
    mgnt = '0; mgnt_next = '0; favour = 1;
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    issue(2, 1'b0, 12'h200, 8'h00);
    run(4);

    // Pointer restarts favouring port 1
    glog.delete();
    issue(1, 1'b0, 12'h202, 8'h00);
    issue(2, 1'b0, 12'h203, 8'h00);
    run(5);
    if (glog.size() >= 2) chk("post_rst_first_p1", 32'(glog[0]), 32'd1);
    else fail("post_rst_grant_count", glog.size(), 2);

    run(5);
    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: RAM address width.
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 Parameter WP_LIMIT, default 12'h200: CPU writes below this address are blocked.
REQ-004 Ports shall be as follows; port index 0 = ROM loader, 1 = CPU, 2 = draw engine.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 resets immediately.
- req  in  3  per-port access request.
- we  in  3  per-port write flag, valid with req.
- addr  in  3*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  per-port write data; same packing.
- gnt  out  3  one-hot grant pulse, registered.
- rvalid  out  3  one-hot read-data-valid pulse, registered.
- rdata  out  DATA_W  read data, shared by all ports.
- wp_fault  out  1  blocked CPU write pulse.
- busy  out  1  access in flight.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable, active-high.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  synchronous-RAM read data, valid one cycle after address.

Function
REQ-005 Eligibility in cycle t: eligible = req & ~gnt; a port granted in cycle t is not re-sampled in t, so one port gets at most one grant per two cycles.
REQ-006 Winner is selected from eligible per REQ-014 or REQ-015; if none, the next cycle has gnt = 0, mem_we = 0 and mem_addr holds.
REQ-007 At the end of cycle t, the block registers gnt = onehot(winner), mem_addr = addr[winner], mem_wdata = wdata[winner] and mem_we = we[winner] & ~blocked.
REQ-008 Requester holds addr/we/wdata stable from req assertion until the cycle gnt is high; data is captured from the cycle before gnt.
REQ-009 To end a request, the requester drops req in the gnt cycle; req still high in the cycle after gnt is a new request.
REQ-010 Read latency: for a read sampled in t, gnt is high in t+1 and rvalid[winner] is high in t+2; rdata = mem_rdata in t+2, passed through combinationally.
REQ-011 rvalid stays 0 for writes; back-to-back grants to different ports are allowed each cycle, and rvalid pulses follow in grant order.
REQ-012 Blocked: port 1, we = 1 and addr < WP_LIMIT; gnt[1] is still issued, mem_we = 0, and wp_fault pulses in the gnt cycle; ports 0 and 2 are never blocked.
REQ-013 busy = |gnt | (read pending for rvalid next cycle).
REQ-014 Fixed priority (macro absent): port 0 > 1 > 2.

Reset
REQ-016 While reset = 0, gnt, rvalid, wp_fault, busy and mem_we are 0, mem_addr and mem_wdata are 0, and the RR pointer favours port 1.
REQ-017 Reset mid-access: pending rvalid is dropped and no write reaches RAM after reset asserts; after release, arbitration restarts from an empty state on the first clock edge.

Configuration
REQ-015 CHIP8_ARB_RR_EN defined: port 0 keeps absolute priority; ports 1 and 2 round-robin with a 1-bit pointer, which after a grant to port 1 or 2 points to the other port. CHIP8_ARB_RR_EN undefined: REQ-014 applies, and the pointer logic is not built.

Verification
REQ-018 Port 1 read addr 0x200, RAM[0x200] = 0xA2 -> gnt[1] at t+1, rvalid[1] at t+2 with rdata = 0xA2.
REQ-019 Ports 1 and 2 held high together for 6 cycles -> fixed priority gives grants 1,2,1,2 (alternation forced by REQ-005); with RR_EN, the pointer also alternates and port 2 is never starved.
REQ-020 Port 1 write 0x55 to 0x1FF -> gnt[1], wp_fault = 1, mem_we = 0, RAM unchanged; the same write to 0x200 -> mem_we = 1 and RAM[0x200] = 0x55.
REQ-021 Ports 0, 1 and 2 all request in the same cycle -> gnt[0] first, then port 1 (fixed priority) or per the pointer (RR_EN), with port 0 never delayed.
REQ-022 Port 2 read granted, then reset pulsed low for one cycle before rvalid -> no rvalid; all outputs 0; the next request is served with normal latency.
